// File: rtl/halt_dump_tx_pkg.sv
// dump_pkg: shared types and defaults for the halt register dump reporter.
//   dump_state_t  - frame sequencer states
//   DUMP_NUM_REGS - number of CPU registers in a dump (A..G, Temp)
//   DUMP_HEADER   - frame start byte
package dump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        SEL,
        LATCH,
        SEND,
        CSUM,
        DONE
    } dump_state_t;

    localparam int         DUMP_NUM_REGS = 8;
    localparam logic [7:0] DUMP_HEADER   = 8'hA5;

endpackage

// File: rtl/halt_dump_tx_if.sv
// halt_dump_tx_if: valid/ready byte stream between the dump reporter and
// its consumer (serial transmitter or debug FIFO).
//   tx_data  - stream byte
//   tx_valid - tx_data holds a byte to transfer
//   tx_ready - consumer accepts the byte; transfer when valid && ready
//   master   - producer side (the reporter)
//   slave    - consumer side
interface halt_dump_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/halt_dump_tx.sv
// halt_dump_tx: when the CPU halts, reads every CPU register through a
// register-select port and streams HEADER, reg[0..NUM_REGS-1], CHECKSUM
// out as bytes. The checksum is the 8-bit wrapping sum of the register bytes.
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   halted   - CPU halted level; its rising edge starts a frame
//   reg_sel  - register index to the CPU register file read port
//   reg_data - register value, valid one cycle after reg_sel changes
//   tx       - byte stream (master side)
//   busy     - a frame is in progress
//   done     - frame complete, held until halted drops
module halt_dump_tx
    import dump_pkg::*;
#(
    parameter int         NUM_REGS = DUMP_NUM_REGS,
    parameter logic [7:0] HEADER   = DUMP_HEADER
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           halted,
    output logic [2:0]     reg_sel,
    input  logic [7:0]     reg_data,
    halt_dump_tx_if.master tx,
    output logic           busy,
    output logic           done
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_REGS - 1);

    dump_state_t state;
    dump_state_t next_state;

    logic       halted_q;
    logic [2:0] idx;
    logic [2:0] sel_q;
    logic [7:0] data_q;
    logic [7:0] acc;
    logic       rise;
    logic       xfer;

    // halted_q starts at 0, so a halted already high out of reset triggers.
    assign rise = halted & ~halted_q;
    assign xfer = tx.tx_valid & tx.tx_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            halted_q <= 1'b0;
        end else begin
            state    <= next_state;
            halted_q <= halted;
        end
    end

    // Triggers are only looked at in IDLE, so halted activity mid-frame
    // neither aborts nor restarts the dump.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (rise) next_state = HDR;
            HDR:     if (xfer) next_state = SEL;
            SEL:     next_state = LATCH;
            LATCH:   next_state = SEND;
            SEND:    if (xfer) next_state = (idx == LAST_IDX) ? CSUM : SEL;
            CSUM:    if (xfer) next_state = DONE;
            DONE:    if (!halted) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Index, held register select, captured byte and running checksum.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx    <= '0;
            sel_q  <= '0;
            data_q <= '0;
            acc    <= '0;
        end else begin
            if (state == IDLE && rise) begin
                idx <= '0;
                acc <= '0;
            end
            if (state == SEL) begin
                sel_q <= idx;
            end
            if (state == LATCH) begin
                data_q <= reg_data;
                acc    <= acc + reg_data;
            end
            if (state == SEND && xfer) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // reg_sel must show the new index during SEL itself so the registered
    // register-file read has reg_data ready when LATCH samples it.
    always_comb begin
        tx.tx_valid = 1'b0;
        tx.tx_data  = data_q;
        reg_sel     = sel_q;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: ;
            HDR: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = HEADER;
                busy        = 1'b1;
            end
            SEL, LATCH: begin
                reg_sel = idx;
                busy    = 1'b1;
            end
            SEND: begin
                tx.tx_valid = 1'b1;
                busy        = 1'b1;
            end
            CSUM: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = acc;
                busy        = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_halt_dump_tx.sv
// tb_halt_dump_tx: randomized self-checking bench for halt_dump_tx. A
// behavioural register file feeds reg_data; the expected frame is computed
// from the register array as header, bytes, and sum modulo 256.
module tb_halt_dump_tx;
    import dump_pkg::*;

    localparam int NREG = DUMP_NUM_REGS;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       halted;
    logic [2:0] reg_sel;
    logic [7:0] reg_data;
    logic       busy;
    logic       done;

    halt_dump_tx_if txif();

    halt_dump_tx #(.NUM_REGS(NREG), .HEADER(8'hA5)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .halted   (halted),
        .reg_sel  (reg_sel),
        .reg_data (reg_data),
        .tx       (txif),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    logic [7:0] regs [NREG];

    // Register file second read port: registered read.
    always @(posedge clk) reg_data <= regs[reg_sel];

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         stall_bad = 0;
    int         last_xfer_cyc = 0;
    int         done_cyc = 0;

    function automatic void build_expected();
        int sum = 0;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < NREG; i++) begin
            exp_q.push_back(regs[i]);
            sum += int'(regs[i]);
        end
        exp_q.push_back(8'(sum % 256));
    endfunction

    function automatic void randomize_regs();
        for (int i = 0; i < NREG; i++) regs[i] = 8'($urandom_range(0, 255));
    endfunction

    // One clock: drive tx_ready at the falling edge, then observe outputs
    // that will be used at the next rising edge.
    task automatic cycle(input logic rdy);
        @(negedge clk);
        txif.tx_ready = rdy;
        cyc++;
        if (prev_stall && !(txif.tx_valid === 1'b1 && txif.tx_data === prev_data)) begin
            stall_bad++;
            $display("[TB] stall broken at cycle %0d: valid=%b data=%h held=%h", cyc, txif.tx_valid, txif.tx_data, prev_data);
        end
        if (txif.tx_valid === 1'b1 && rdy) begin
            rx_q.push_back(txif.tx_data);
            last_xfer_cyc = cyc;
        end
        prev_stall = (txif.tx_valid === 1'b1) && !rdy;
        prev_data  = txif.tx_data;
    endtask

    // mode 0: always ready; 1: alternating ready with random stalls on
    // header and checksum; 2: always ready with halted toggled mid-frame.
    task automatic collect_frame(input int mode, input int budget);
        logic rdy;
        for (int n = 0; n < budget; n++) begin
            rdy = 1'b1;
            if (mode == 1) begin
                if (rx_q.size() == 0 || rx_q.size() == NREG + 1) rdy = 1'($urandom_range(0, 1));
                else rdy = (cyc % 2 == 0);
            end else if (mode == 2) begin
                if (n == 2 || n == 7) halted = 1'b0;
                if (n == 4 || n == 9) halted = 1'b1;
            end
            cycle(rdy);
            if (done === 1'b1) begin
                done_cyc = cyc;
                return;
            end
        end
        n_cmp++; n_err++;
        $display("[TB] FAIL frame_timeout: done not seen within %0d cycles, got done=%b want 1", budget, done);
    endtask

    task automatic idle_low();
        halted = 1'b0;
        cycle(1'b1);
        cycle(1'b1);
        rx_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        halted = 1'b0;
        txif.tx_ready = 1'b0;
        for (int i = 0; i < NREG; i++) regs[i] = 8'h00;
        #23;
        n_cmp++; if (txif.tx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tx_valid: got %b want 0", txif.tx_valid); end
        n_cmp++; if (txif.tx_data !== 8'h00) begin n_err++; $display("[TB] FAIL reset_tx_data: got %h want 00", txif.tx_data); end
        n_cmp++; if (reg_sel !== 3'd0) begin n_err++; $display("[TB] FAIL reset_reg_sel: got %0d want 0", reg_sel); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        @(negedge clk);
        reset_n = 1'b1;
        prev_stall = 1'b0;
        cycle(1'b1);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL idle_no_trigger: busy got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int hdr_cyc;
        for (int i = 0; i < NREG; i++) regs[i] = 8'(i + 1);
        idle_low();
        build_expected();
        halted = 1'b1;
        cycle(1'b1);
        hdr_cyc = cyc;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL basic_busy_latency: got %b want 1", busy); end
        n_cmp++; if (txif.tx_valid !== 1'b1 || txif.tx_data !== 8'hA5) begin n_err++; $display("[TB] FAIL basic_header: valid=%b data=%h want 1/a5", txif.tx_valid, txif.tx_data); end
        collect_frame(0, 100);
        n_cmp++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL basic_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL basic_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        n_cmp++; if (last_xfer_cyc - hdr_cyc + 1 != 26) begin n_err++; $display("[TB] FAIL basic_frame_cycles: got %0d want 26", last_xfer_cyc - hdr_cyc + 1); end
        n_cmp++; if (done_cyc != last_xfer_cyc + 1) begin n_err++; $display("[TB] FAIL basic_done_latency: got %0d want %0d", done_cyc - last_xfer_cyc, 1); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL basic_busy_end: got %b want 0", busy); end
        n_cmp++; if (reg_sel !== 3'(NREG - 1)) begin n_err++; $display("[TB] FAIL basic_reg_sel_hold: got %0d want %0d", reg_sel, NREG - 1); end
    endtask

    task automatic test_rearm();
        rx_q.delete();
        repeat (20) cycle(1'b1);
        n_cmp++; if (rx_q.size() != 0) begin n_err++; $display("[TB] FAIL rearm_held_high: got %0d bytes want 0", rx_q.size()); end
        n_cmp++; if (done !== 1'b1) begin n_err++; $display("[TB] FAIL rearm_done_held: got %b want 1", done); end
        halted = 1'b0;
        cycle(1'b1);
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("[TB] FAIL rearm_done_clear: got %b want 0", done); end
        cycle(1'b1);
        randomize_regs();
        build_expected();
        halted = 1'b1;
        collect_frame(0, 100);
        repeat (10) cycle(1'b1);
        n_cmp++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL rearm_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL rearm_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_checksum_wrap();
        idle_low();
        for (int i = 0; i < NREG; i++) regs[i] = 8'hFF;
        build_expected();
        halted = 1'b1;
        collect_frame(0, 100);
        n_cmp++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL wrap_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL wrap_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
        if (rx_q.size() == NREG + 2) begin
            n_cmp++; if (rx_q[NREG + 1] !== 8'hF8) begin n_err++; $display("[TB] FAIL wrap_csum: got %h want f8", rx_q[NREG + 1]); end
        end
    endtask

    task automatic test_back_to_back_stalls();
        for (int rep = 0; rep < 3; rep++) begin
            idle_low();
            randomize_regs();
            build_expected();
            stall_bad = 0;
            halted = 1'b1;
            collect_frame(1, 400);
            n_cmp++; if (stall_bad != 0) begin n_err++; $display("[TB] FAIL bp_stall_stable: got %0d broken stalls want 0", stall_bad); end
            n_cmp++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL bp_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
                n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL bp_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_trigger_noise();
        idle_low();
        randomize_regs();
        build_expected();
        halted = 1'b1;
        collect_frame(2, 200);
        repeat (10) cycle(1'b1);
        n_cmp++; if (rx_q.size() != NREG + 2) begin n_err++; $display("[TB] FAIL noise_len: got %0d want %0d", rx_q.size(), NREG + 2); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL noise_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        idle_low();
        randomize_regs();
        build_expected();
        halted = 1'b1;
        n = 0;
        while (rx_q.size() < 4 && n < 100) begin
            cycle(1'b1);
            n++;
        end
        cycle(1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (txif.tx_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mrst_tx_valid: got %b want 0", txif.tx_valid); end
        n_cmp++; if (txif.tx_data !== 8'h00) begin n_err++; $display("[TB] FAIL mrst_tx_data: got %h want 00", txif.tx_data); end
        n_cmp++; if (reg_sel !== 3'd0) begin n_err++; $display("[TB] FAIL mrst_reg_sel: got %0d want 0", reg_sel); end
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("[TB] FAIL mrst_busy_done: got %b/%b want 0/0", busy, done); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        prev_stall = 1'b0;
        rx_q.delete();
        collect_frame(0, 100);
        n_cmp++; if (rx_q.size() != exp_q.size()) begin n_err++; $display("[TB] FAIL mrst_len: got %0d want %0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_cmp++; if (rx_q[i] !== exp_q[i]) begin n_err++; $display("[TB] FAIL mrst_byte%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_rearm();
        test_checksum_wrap();
        test_back_to_back_stalls();
        test_trigger_noise();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/halt_dump_tx.md
# halt_dump_tx

Hardware reporter that, when the CPU asserts `halted`, reads the eight CPU registers (A, B, C, D, E, F, G, Temp) one at a time through a register-select port. It then streams them out as a framed byte sequence on a valid/ready byte interface. It sits beside the CPU in the machine top level and feeds a serial transmitter or debug FIFO, giving a synthesizable equivalent of the end-of-run register printout.

## Interface
- `NUM_REGS`, default 8: registers dumped, indexes 0..NUM_REGS-1 (A..G, Temp).
- `HEADER`, default 8'hA5: frame start byte.
- `clk` in 1: system clock. All logic runs on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `halted` in 1: CPU halted flag. Level input, synchronous to `clk`.
- `reg_sel` out 3: register index presented to the CPU register file.
- `reg_data` in 8: register value. It is valid one cycle after `reg_sel` changes (registered read).
- `tx_data` out 8: stream byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: downstream accepts the byte. A transfer occurs when `tx_valid && tx_ready`.
- `busy` out 1: a frame is in progress.
- `done` out 1: frame complete. Held until re-armed.

## Operation
- Frame format is HEADER, reg[0] … reg[NUM_REGS-1], CHECKSUM, for NUM_REGS+2 bytes.
- CHECKSUM is the sum of the register bytes only, mod 256. Carries are discarded and the accumulator is 8 bits wide.
- The trigger is the rising edge of `halted`, detected against a registered copy of it (`halted_q`).
- States and transitions:
  - IDLE: a rising edge moves to HDR and sets `busy`. The accumulator and index are cleared.
  - HDR: drives `tx_data`=HEADER with `tx_valid`=1. On transfer, moves to SEL.
  - SEL: drives `reg_sel`=index with `tx_valid`=0. Moves to LATCH the next cycle.
  - LATCH: captures `reg_data` into `tx_data` and adds it to the accumulator. Moves to SEND.
  - SEND: `tx_valid`=1. On transfer, increments the index. If index==NUM_REGS-1, moves to CSUM; otherwise moves to SEL.
  - CSUM: `tx_data`=accumulator, `tx_valid`=1. On transfer, moves to DONE.
  - DONE: `done`=1 and `busy`=0. Stays in DONE while `halted`=1. Returns to IDLE when `halted`=0, which re-arms the trigger.
- `halted` edges while `busy` is set are ignored. A fall of `halted` mid-frame does not abort; the frame completes.
- Once asserted, `tx_valid` is never deasserted without a transfer. `tx_data` is stable while `tx_valid && !tx_ready`.
- `reg_sel` holds its last value outside SEL and LATCH.
- The core only reads the register file and never writes it.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `reg_sel`=0, `busy`=0, `done`=0, state=IDLE, `halted_q`=0.
- Assertion of `reset_n` clears everything immediately, including mid-frame. No partial byte is completed. After release, a `halted` that is already high counts as a rising edge on the first clock.
- If `halted` rises at edge N, `busy` and the HEADER `tx_valid` are visible after edge N+1.
- Each register byte takes 3 cycles from the previous transfer to the next `tx_valid` (SEL, LATCH, SEND).
- A minimum frame with `tx_ready` tied high takes 1 + 3·NUM_REGS + 1 cycles from HEADER valid to the CSUM transfer, i.e. 26 cycles for NUM_REGS=8.
- `done` rises one cycle after the CSUM transfer.

## Structure
- Package `dump_pkg`:
  - state enum `dump_state_t` (IDLE, HDR, SEL, LATCH, SEND, CSUM, DONE);
  - constants `DUMP_HEADER` and `DUMP_NUM_REGS`.
- Single module; no sub-modules. The edge detector, FSM, index counter and accumulator are inline.
- The machine top level connects `reg_sel` and `reg_data` to a second read port of the CPU register file.

## Test plan
- **Basic frame:** regs = 01,02,…,08 with `tx_ready`=1, then `halted` 0→1. The stream is A5 01 02 03 04 05 06 07 08 24, followed by `done`=1.
- **Checksum wrap:** all regs = FF. Stream is A5, then FF ×8, then F8.
- **Backpressure:** `tx_ready` toggles 1/0 each cycle, with random stalls on HEADER and CSUM. No byte is lost or duplicated, and `tx_data` is stable during every stall.
- **Re-arm:** `halted` is held high after `done`, and no second frame starts. `halted` then goes 0 and back to 1, and exactly one new frame is sent with the current register values.
- **Trigger noise:** `halted` drops and rises twice while `busy`. Exactly one frame is produced, with 10 bytes.
- **Mid-frame reset:** `reset_n`=0 during the 4th register byte. All outputs go to their reset values immediately. After release with `halted`=1, a full frame restarting at A5 is sent.
